// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared constants and helpers for the AES round datapath stages
// (ShiftRows pipeline today, MixColumns successor later).
//   NB_MIN / NB_MAX : supported Rijndael block widths in columns
//   MODE_*          : per-transaction transform select
//   rowOffset()     : cyclic shift applied to row r for a given block width
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int NB_MIN = 4;
    localparam int NB_MAX = 8;

    localparam logic [1:0] MODE_FWD = 2'b00;
    localparam logic [1:0] MODE_INV = 2'b01;
    localparam logic [1:0] MODE_BYP = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    // Rijndael uses offsets 0,1,2,3 for 4/6 columns and 0,1,3,4 for 8.
    function automatic int rowOffset(input int nb, input int r);
        if (nb == 8 && r >= 2) begin
            return r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// ---------------------------------------------------------------------------
// shift_rows_perm
// Combinational ShiftRows / InvShiftRows / bypass byte permutation.
// Ports:
//   mode  in  2     MODE_FWD, MODE_INV, anything else passes through
//   in    in  32*NB state, byte s[r][c] at [W-1-8*(4c+r) -: 8]
//   out   out 32*NB permuted state, same packing
// ---------------------------------------------------------------------------
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [1:0]         mode,
    input  logic [32*NB-1:0]   in,
    output logic [32*NB-1:0]   out
);

    localparam int W = 32 * NB;

    logic [W-1:0] fwdState;
    logic [W-1:0] invState;

    // Pure wiring: each output byte is a fixed source byte per direction.
    for (genvar r = 0; r < 4; r++) begin : gRow
        localparam int OFF = rowOffset(NB, r);
        for (genvar c = 0; c < NB; c++) begin : gCol
            localparam int FWD_SRC = (c + OFF) % NB;
            localparam int INV_SRC = (c + NB - OFF) % NB;
            assign fwdState[W-1-8*(4*c+r) -: 8] = in[W-1-8*(4*FWD_SRC+r) -: 8];
            assign invState[W-1-8*(4*c+r) -: 8] = in[W-1-8*(4*INV_SRC+r) -: 8];
        end
    end

    always_comb begin
        out = in;
        case (mode)
            MODE_FWD: out = fwdState;
            MODE_INV: out = invState;
            default:  out = in;
        endcase
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// shift_rows_pipe
// Flow-controlled ShiftRows stage: permutes on the input side and stores the
// result with its tag in a DEPTH-entry circular FIFO.
// Ports:
//   clk, rstN                 clock, synchronous active-low reset
//   inValid/inReady           input handshake
//   inMode[1:0]               00 fwd, 01 inverse, 10 bypass, 11 bypass+flag
//   inState[W-1:0], inTag     state and sideband tag
//   outValid/outReady         output handshake
//   outState, outTag          head entry
//   outBadMode                head entry was submitted with mode 11
// ---------------------------------------------------------------------------
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int DEPTH = 2,
    parameter int TAGW  = 4
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                inValid,
    output logic                inReady,
    input  logic [1:0]          inMode,
    input  logic [32*NB-1:0]    inState,
    input  logic [TAGW-1:0]     inTag,
    output logic                outValid,
    input  logic                outReady,
    output logic [32*NB-1:0]    outState,
    output logic [TAGW-1:0]     outTag,
    output logic                outBadMode
);

    localparam int W        = 32 * NB;
    localparam int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS    = 1 << PW;
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [2:0]    DEPTH_CNT = 3'(DEPTH);

    if (NB < NB_MIN || NB > NB_MAX || NB == 5 || NB == 7) begin : gBadNb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (DEPTH < 1 || DEPTH > 4) begin : gBadDepth
        $error("shift_rows_pipe: DEPTH must be 1..4");
    end

    logic [W-1:0]    permState;
    logic            push;
    logic            pop;
    logic [PW-1:0]   wrPtr;
    logic [PW-1:0]   rdPtr;
    logic [2:0]      count;

    // Storage is rounded up to a power of two so pointer width matches the
    // index width; slots at or beyond DEPTH are never addressed.
    logic [W-1:0]    memState [0:SLOTS-1];
    logic [TAGW-1:0] memTag   [0:SLOTS-1];
    logic            memBad   [0:SLOTS-1];

    shift_rows_perm #(.NB(NB)) uPerm (
        .mode (inMode),
        .in   (inState),
        .out  (permState)
    );

    // Full buffer can still accept when the head leaves in the same cycle.
    assign inReady  = rstN && ((count < DEPTH_CNT) || outReady);
    assign outValid = (count != 3'd0);
    assign push     = inValid && inReady;
    assign pop      = outValid && outReady;

    assign outState   = memState[rdPtr];
    assign outTag     = memTag[rdPtr];
    assign outBadMode = memBad[rdPtr];

    always_ff @(posedge clk) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            // Cleared so the outputs read zero while the buffer is empty.
            for (int i = 0; i < SLOTS; i++) begin
                memState[i] <= '0;
                memTag[i]   <= '0;
                memBad[i]   <= 1'b0;
            end
        end else begin
            if (push) begin
                memState[wrPtr] <= permState;
                memTag[wrPtr]   <= inTag;
                memBad[wrPtr]   <= (inMode == MODE_RSV);
                wrPtr           <= (wrPtr == LAST_PTR) ? '0 : wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// tb_shift_rows_pipe
// Scoreboard bench: two instances (NB=4/DEPTH=2 and NB=8/DEPTH=1).
// Drivers push hand-computed expected entries at accept; monitors pop and
// compare whenever an output handshake occurs.
// ---------------------------------------------------------------------------
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN;

    // Instance A: NB=4, DEPTH=2
    logic         inValidA, inReadyA, outValidA, outReadyA, outBadModeA;
    logic [1:0]   inModeA;
    logic [127:0] inStateA, outStateA;
    logic [3:0]   inTagA, outTagA;

    // Instance B: NB=8, DEPTH=1
    logic         inValidB, inReadyB, outValidB, outReadyB, outBadModeB;
    logic [1:0]   inModeB;
    logic [255:0] inStateB, outStateB;
    logic [3:0]   inTagB, outTagB;

    shift_rows_pipe #(.NB(4), .DEPTH(2), .TAGW(4)) dutA (
        .clk(clk), .rstN(rstN),
        .inValid(inValidA), .inReady(inReadyA), .inMode(inModeA),
        .inState(inStateA), .inTag(inTagA),
        .outValid(outValidA), .outReady(outReadyA), .outState(outStateA),
        .outTag(outTagA), .outBadMode(outBadModeA)
    );

    shift_rows_pipe #(.NB(8), .DEPTH(1), .TAGW(4)) dutB (
        .clk(clk), .rstN(rstN),
        .inValid(inValidB), .inReady(inReadyB), .inMode(inModeB),
        .inState(inStateB), .inTag(inTagB),
        .outValid(outValidB), .outReady(outReadyB), .outState(outStateB),
        .outTag(outTagB), .outBadMode(outBadModeB)
    );

    typedef struct {
        logic [255:0] st;
        logic [3:0]   tag;
        logic         bad;
    } ent_t;

    ent_t qA[$];
    ent_t qB[$];

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] SEQ4     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ4_FWD = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [255:0] SEQ8     =
        256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
    localparam logic [255:0] SEQ8_FWD =
        256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;

    function automatic void check(input string name, input logic [255:0] act,
                                  input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Monitors sample at the falling edge; a handshake seen here completes
    // at the following rising edge.
    always @(negedge clk) begin
        if (rstN && outValidA && outReadyA) begin
            if (qA.size() == 0) begin
                total++;
                bad++;
                $display("FAIL A unexpected output: got tag %h want none", outTagA);
            end else begin
                ent_t e;
                e = qA.pop_front();
                check("A state", 256'(outStateA), e.st);
                check("A tag", 256'(outTagA), 256'(e.tag));
                check("A badMode", 256'(outBadModeA), 256'(e.bad));
            end
        end
    end

    always @(negedge clk) begin
        if (rstN && outValidB && outReadyB) begin
            if (qB.size() == 0) begin
                total++;
                bad++;
                $display("FAIL B unexpected output: got tag %h want none", outTagB);
            end else begin
                ent_t e;
                e = qB.pop_front();
                check("B state", outStateB, e.st);
                check("B tag", 256'(outTagB), 256'(e.tag));
                check("B badMode", 256'(outBadModeB), 256'(e.bad));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic sendA(input logic [127:0] st, input logic [1:0] md,
                         input logic [3:0] tg, input logic [127:0] exp,
                         input logic expBad, output int waited);
        bit done;
        ent_t e;
        inValidA = 1'b1; inStateA = st; inModeA = md; inTagA = tg;
        waited = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (inReadyA) begin
                e.st = 256'(exp); e.tag = tg; e.bad = expBad;
                qA.push_back(e);
                done = 1;
            end else begin
                waited++;
                if (waited > 50) begin
                    total++; bad++;
                    $display("FAIL A accept timeout: got no inReady want inReady within 50 cycles");
                    done = 1;
                end
            end
            @(posedge clk); #1;
        end
        inValidA = 1'b0;
    endtask

    task automatic sendB(input logic [255:0] st, input logic [1:0] md,
                         input logic [3:0] tg, input logic [255:0] exp,
                         input logic expBad, output int waited);
        bit done;
        ent_t e;
        inValidB = 1'b1; inStateB = st; inModeB = md; inTagB = tg;
        waited = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (inReadyB) begin
                e.st = exp; e.tag = tg; e.bad = expBad;
                qB.push_back(e);
                done = 1;
            end else begin
                waited++;
                if (waited > 50) begin
                    total++; bad++;
                    $display("FAIL B accept timeout: got no inReady want inReady within 50 cycles");
                    done = 1;
                end
            end
            @(posedge clk); #1;
        end
        inValidB = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qA.size() != 0 || qB.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (qA.size() != 0 || qB.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: got %0d/%0d entries pending want 0/0", qA.size(), qB.size());
            qA.delete();
            qB.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rstN = 1'b0;
        inValidA = 0; inModeA = 0; inStateA = '0; inTagA = 0; outReadyA = 0;
        inValidB = 0; inModeB = 0; inStateB = '0; inTagB = 0; outReadyB = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outValidA", 256'(outValidA), 256'(0));
        check("reset outStateA", 256'(outStateA), 256'(0));
        check("reset inReadyA low", 256'(inReadyA), 256'(0));
        check("reset outValidB", 256'(outValidB), 256'(0));
        check("reset inReadyB low", 256'(inReadyB), 256'(0));
        @(posedge clk); #1;
        rstN = 1'b1;
        outReadyA = 1'b1;
        outReadyB = 1'b1;

        // Transform vectors on A, back-to-back at full rate
        sendA(SEQ4, 2'b00, 4'h1, SEQ4_FWD, 1'b0, w);
        check("A first accept wait", 256'(w), 256'(0));
        sendA(SEQ4_FWD, 2'b01, 4'h2, SEQ4, 1'b0, w);
        check("A back-to-back wait", 256'(w), 256'(0));
        sendA(FIPS_IN, 2'b00, 4'h3, FIPS_OUT, 1'b0, w);
        sendA(FIPS_OUT, 2'b01, 4'h4, FIPS_IN, 1'b0, w);
        sendA(FIPS_IN, 2'b10, 4'h5, FIPS_IN, 1'b0, w);
        sendA(SEQ4, 2'b11, 4'h7, SEQ4, 1'b1, w);
        check("A sustained wait", 256'(w), 256'(0));

        // NB=8 on B, DEPTH=1 must still run at one per cycle
        sendB(SEQ8, 2'b00, 4'h9, SEQ8_FWD, 1'b0, w);
        check("B first accept wait", 256'(w), 256'(0));
        sendB(SEQ8_FWD, 2'b01, 4'ha, SEQ8, 1'b0, w);
        check("B depth1 throughput wait", 256'(w), 256'(0));
        sendB(SEQ8, 2'b11, 4'hb, SEQ8, 1'b1, w);
        drain();

        // Backpressure on A: tags 1,2 fill the buffer, tag 3 stalls
        outReadyA = 1'b0;
        sendA(128'h11111111222222223333333344444444, 2'b10, 4'h1,
              128'h11111111222222223333333344444444, 1'b0, w);
        sendA(128'haaaaaaaabbbbbbbbccccccccdddddddd, 2'b10, 4'h2,
              128'haaaaaaaabbbbbbbbccccccccdddddddd, 1'b0, w);
        check("A second accept while stalled", 256'(w), 256'(0));
        inValidA = 1'b1; inStateA = SEQ4; inModeA = 2'b00; inTagA = 4'h3;
        @(negedge clk);
        check("A full inReady", 256'(inReadyA), 256'(0));
        check("A full head tag", 256'(outTagA), 256'(4'h1));
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("A full inReady held", 256'(inReadyA), 256'(0));
            check("A full head held", 256'(outStateA),
                  256'(128'h11111111222222223333333344444444));
        end
        @(posedge clk); #1;
        outReadyA = 1'b1;
        @(negedge clk);
        check("A full push+pop inReady", 256'(inReadyA), 256'(1));
        begin
            ent_t e;
            e.st = 256'(SEQ4_FWD); e.tag = 4'h3; e.bad = 1'b0;
            qA.push_back(e);
        end
        @(posedge clk); #1;
        inValidA = 1'b0;
        @(negedge clk);
        check("A after push+pop valid", 256'(outValidA), 256'(1));
        check("A after push+pop head", 256'(outTagA), 256'(4'h2));
        @(posedge clk); #1;
        drain();

        // Reset with two entries buffered
        outReadyA = 1'b0;
        sendA(FIPS_IN, 2'b11, 4'hc, FIPS_IN, 1'b1, w);
        sendA(FIPS_IN, 2'b00, 4'hd, FIPS_OUT, 1'b0, w);
        rstN = 1'b0;
        @(negedge clk);
        check("A inReady during reset", 256'(inReadyA), 256'(0));
        @(posedge clk); #1;
        rstN = 1'b1;
        qA.delete();
        @(negedge clk);
        check("A post-reset outValid", 256'(outValidA), 256'(0));
        check("A post-reset outState", 256'(outStateA), 256'(0));
        check("A post-reset outTag", 256'(outTagA), 256'(0));
        check("A post-reset outBadMode", 256'(outBadModeA), 256'(0));
        check("A post-reset inReady", 256'(inReadyA), 256'(1));
        @(posedge clk); #1;
        outReadyA = 1'b1;

        // Recovery after reset
        sendA(FIPS_IN, 2'b00, 4'he, FIPS_OUT, 1'b0, w);
        check("A post-reset accept wait", 256'(w), 256'(0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
